// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a start/data/stop
// serialiser that runs queued frames back-to-back at CLKS_PER_BIT clocks per bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          TXD,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          not_empty;
  logic          accept;
  logic          pop;
  logic          baud_tc;

  // Ready depends only on the registered count, so a same-cycle pop never frees a slot.
  assign not_empty = (count != '0);
  assign wr_ready  = (count != FULL_CNT);
  assign accept    = wr_valid && wr_ready;
  assign baud_tc   = (baud_cnt == BAUD_LAST);
  assign pop       = not_empty && ((state == IDLE) || ((state == STOP) && baud_tc));
  assign level     = count;
  assign busy      = (state != IDLE) || not_empty;

  // NOTE: FIFO storage has no reset; emptiness is tracked by count alone, so stale bytes are never read.
  always_ff @(posedge CLK) begin
    if (accept) mem[wr_ptr] <= wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (pop && !accept) count <= count - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      TXD      <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      if (state == IDLE || baud_tc) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            shift <= mem[rd_ptr];
            TXD   <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_tc) begin
            TXD     <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_tc) begin
            shift <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              TXD   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              TXD     <= shift[1];
            end
          end
        end
        STOP: begin
          // A queued byte starts its start bit immediately, with no idle cycle.
          if (baud_tc) begin
            if (pop) begin
              shift <= mem[rd_ptr];
              TXD   <= 1'b0;
              state <= START;
            end else begin
              TXD   <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
